// File: rtl/ro_freq_meter.sv
// Multi-channel ring-oscillator frequency meter.
// Enables one ring, lets its synchroniser settle, counts synchronised rising
// edges over a programmable window of clk cycles and latches the result for
// parallel or MSB-first serial readout.
module ro_freq_meter #(
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 2,
  parameter int GATE_W      = 16,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CYC  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic [GATE_W-1:0] gate_cycles,
  input  logic [NUM_CH-1:0] osc_in,
  output logic [NUM_CH-1:0] ring_ena,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  input  logic              shift_en,
  output logic              shift_out
);

  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int TMR_W = (GATE_W > SET_W) ? GATE_W : SET_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                accept;
  logic [CH_W-1:0]     ch_q;
  logic [GATE_W-1:0]   gate_q;
  logic [TMR_W-1:0]    timer;
  logic                osc_sel;
  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                hist;
  logic                rise;
  logic [CNT_W-1:0]    counter;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                ovf_nxt;
  logic [CNT_W-1:0]    shreg;

  // Saturating increment: the counter sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Timer reload for the measurement window; a zero gate still gives one cycle.
  function automatic logic [TMR_W-1:0] gate_load(input logic [GATE_W-1:0] g);
    return (g == '0) ? '0 : TMR_W'(g) - 1'b1;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; start is only honoured when not busy.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = SETTLE;
          accept    = 1'b1;
        end
      end
      SETTLE:  if (timer == '0) state_nxt = MEASURE;
      MEASURE: if (timer == '0) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Phase timer: counts down the settle period, then the gate window.
  always_ff @(posedge clk) begin
    if (reset)                                timer <= '0;
    else if (accept)                          timer <= TMR_W'(SETTLE_CYC - 1);
    else if (state == SETTLE && timer == '0)  timer <= gate_load(gate_q);
    else if (timer != '0)                     timer <= timer - 1'b1;
  end

  // Measurement configuration captured when a start is accepted.
  always_ff @(posedge clk) begin
    if (accept) begin
      ch_q   <= ch_sel;
      gate_q <= gate_cycles;
    end
  end

  // Channel mux; out-of-range selections read as a quiet input.
  always_comb begin
    osc_sel = 1'b0;
    for (int i = 0; i < NUM_CH; i++)
      if (ch_q == CH_W'(i)) osc_sel = osc_in[i];
  end

  // Synchroniser chain plus history flop; runs continuously so the settle
  // period leaves it filled with the selected ring before the gate opens.
  always_ff @(posedge clk) begin
    sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], osc_sel};
    hist      <= sync_pipe[SYNC_STAGES-1];
  end

  assign rise = sync_pipe[SYNC_STAGES-1] & ~hist;

  // Edge accumulation during the gate window, with sticky overflow.
  always_comb begin
    cnt_nxt = counter;
    ovf_nxt = overflow;
    if (state == MEASURE && rise) begin
      if (counter == CNT_MAX) ovf_nxt = 1'b1;
      cnt_nxt = sat_inc(counter);
    end
  end

  // Counter, latched result and serial shifter; start takes priority over shifting.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter  <= '0;
      overflow <= 1'b0;
      count    <= '0;
      shreg    <= '0;
    end else if (accept) begin
      counter  <= '0;
      overflow <= 1'b0;
    end else if (state == MEASURE) begin
      counter  <= cnt_nxt;
      overflow <= ovf_nxt;
      if (timer == '0) begin
        count <= cnt_nxt;
        shreg <= cnt_nxt;
      end
    end else if (state == DONE && shift_en) begin
      shreg <= {shreg[CNT_W-2:0], 1'b0};
    end
  end

  assign busy      = (state == SETTLE) || (state == MEASURE);
  assign done      = (state == DONE);
  assign shift_out = shreg[CNT_W-1];

  // Ring enable follows the latched channel while a measurement is in progress.
  always_comb begin
    ring_ena = '0;
    for (int i = 0; i < NUM_CH; i++)
      ring_ena[i] = busy && (ch_q == CH_W'(i));
  end

endmodule
